// File: rtl/output_unit_fifo.sv
// output_unit_fifo: buffered CU output port with four-phase write handshake, FIFO and rate-limited display drain
// Ports: clk/rst_b (async active-low); out_req/out_data/out_fmt/out_ack form the CU handshake;
// flush clears the FIFO; disp_valid/disp_data/disp_fmt present popped entries;
// fifo_count/full/empty report occupancy; total_out counts emitted values.
// Build option: define OUTPUT_UNIT_DISPLAY_EN to print each popped value in simulation.
module output_unit_fifo #(
  parameter int DW        = 16,
  parameter int DEPTH     = 4,
  parameter int AW        = $clog2(DEPTH),
  parameter int DRAIN_DIV = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          out_req,
  input  logic [DW-1:0] out_data,
  input  logic [1:0]    out_fmt,
  output logic          out_ack,
  input  logic          flush,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  output logic [1:0]    disp_fmt,
  output logic [AW:0]   fifo_count,
  output logic          full,
  output logic          empty,
  output logic [15:0]   total_out
);
  localparam int CW = DRAIN_DIV > 1 ? $clog2(DRAIN_DIV) : 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t        state_q, state_d;
  logic [DW+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] div_q, div_d;
  logic          valid_q, valid_d;
  logic [DW+1:0] head_q, head_d;
  logic [15:0]   total_q, total_d;
  logic          accept, push, pop;
  assign full   = count_q == (AW+1)'(DEPTH);
  assign empty  = count_q == '0;
  // a flush still lets the handshake complete, it only drops the data
  assign accept = state_q == IDLE && out_req && !full;
  assign push   = accept && !flush;
  assign pop    = !empty && div_q == '0 && !flush;
  always_comb begin
    state_d  = state_q == IDLE ? (accept ? ACK : IDLE) : (out_req ? ACK : IDLE);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    div_d    = flush ? '0 : pop ? CW'(DRAIN_DIV - 1) : div_q - CW'(div_q != '0);
    valid_d  = pop;
    head_d   = pop ? mem_q[rd_ptr_q] : head_q;
    total_d  = total_q + 16'(pop);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_q    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      total_q  <= total_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {out_fmt, out_data};
  assign out_ack    = state_q == ACK;
  assign disp_valid = valid_q;
  assign disp_fmt   = head_q[DW+1:DW];
  assign disp_data  = head_q[DW-1:0];
  assign fifo_count = count_q;
  assign total_out  = total_q;
`ifdef OUTPUT_UNIT_DISPLAY_EN
  always_ff @(posedge clk)
    if (rst_b && pop)
      case (head_d[DW+1:DW])
        2'd0:    $display("[OUTPUT_UNIT] OUT> %0d", head_d[DW-1:0]);
        2'd1:    $display("[OUTPUT_UNIT] OUT> %0d", $signed(head_d[DW-1:0]));
        2'd2:    $display("[OUTPUT_UNIT] OUT> 0x%h", head_d[DW-1:0]);
        default: $display("[OUTPUT_UNIT] OUT> 0b%b", head_d[DW-1:0]);
      endcase
`else
`endif
endmodule

// File: tb/tb_output_unit_fifo.sv
// tb_output_unit_fifo: randomized and directed check of output_unit_fifo against a queue-based reference model
module tb_output_unit_fifo;
  localparam int DEPTH = 4;
  localparam int DD    = 16;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        out_req = 1'b0;
  logic [15:0] out_data = '0;
  logic [1:0]  out_fmt = '0;
  logic        out_ack;
  logic        flush = 1'b0;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic [1:0]  disp_fmt;
  logic [2:0]  fifo_count;
  logic        full, empty;
  logic [15:0] total_out;
  int n_chk = 0;
  int n_pass = 0;
  bit saw_stall = 0;
  logic [15:0] tot_snap;
  output_unit_fifo #(.DW(16), .DEPTH(DEPTH), .DRAIN_DIV(DD)) u_dut (
    .clk(clk), .rst_b(rst_b), .out_req(out_req), .out_data(out_data), .out_fmt(out_fmt),
    .out_ack(out_ack), .flush(flush), .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_fmt(disp_fmt), .fifo_count(fifo_count), .full(full), .empty(empty), .total_out(total_out)
  );
  always #5 clk = ~clk;
  logic [17:0] q[$];
  bit          m_ack, m_valid, acc, pop;
  logic [15:0] m_data, m_total;
  logic [1:0]  m_fmt;
  logic [17:0] hd;
  int          m_div;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q.delete();
      m_ack = 0; m_valid = 0; m_data = '0; m_fmt = '0; m_total = '0; m_div = 0;
    end else begin
      acc = !m_ack && out_req && q.size() < DEPTH;
      pop = q.size() != 0 && m_div == 0 && !flush;
      m_valid = pop;
      if (pop) begin
        hd = q.pop_front();
        {m_fmt, m_data} = hd;
        m_total++;
        m_div = DD - 1;
      end else if (m_div != 0) m_div--;
      if (flush) begin
        q.delete();
        m_div = 0;
      end else if (acc) q.push_back({out_fmt, out_data});
      m_ack = m_ack ? out_req : acc;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  task automatic cmp_all();
    chk("ack", 32'(out_ack), 32'(m_ack));
    chk("valid", 32'(disp_valid), 32'(m_valid));
    chk("data", 32'(disp_data), 32'(m_data));
    chk("fmt", 32'(disp_fmt), 32'(m_fmt));
    chk("count", 32'(fifo_count), q.size());
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("total", 32'(total_out), 32'(m_total));
  endtask
  task automatic step();
    @(negedge clk);
    cmp_all();
    if (out_req && !out_ack && full) saw_stall = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic hs(input logic [15:0] d, input logic [1:0] f);
    int n;
    out_data = d; out_fmt = f; out_req = 1'b1;
    n = 0;
    do begin step(); n++; end while (!out_ack && n < 400);
    chk("hs_ack_rise", 32'(out_ack), 32'd1);
    out_req = 1'b0;
    step();
    chk("hs_ack_fall", 32'(out_ack), 32'd0);
  endtask
  initial begin
    idle(3);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_total", 32'(total_out), 32'd0);
    rst_b = 1'b1;
    idle(2);
    hs(16'd42, 2'd0);
    chk("t1_valid", 32'(disp_valid), 32'd1);
    chk("t1_data", 32'(disp_data), 32'd42);
    chk("t1_total", 32'(total_out), 32'd1);
    idle(100);
    for (int i = 1; i <= 6; i++) hs(16'(i), 2'd0);
    idle(120);
    chk("stall_seen", 32'(saw_stall), 32'd1);
    hs(16'hFFFF, 2'd1);
    chk("neg_valid", 32'(disp_valid), 32'd1);
    chk("neg_data", 32'(disp_data), 32'hFFFF);
    chk("neg_fmt", 32'(disp_fmt), 32'd1);
    idle(40);
    for (int i = 0; i < 4; i++) hs(16'(16'hA0 + i), 2'd2);
    chk("pre_flush_cnt", 32'(fifo_count), 32'd3);
    tot_snap = total_out;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_cnt", 32'(fifo_count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_total", 32'(total_out), 32'(tot_snap));
    for (int i = 0; i < 40; i++) begin
      step();
      chk("flush_nopop", 32'(disp_valid), 32'd0);
    end
    hs(16'd7, 2'd3);
    hs(16'd8, 2'd3);
    out_data = 16'd9; out_fmt = 2'd3; out_req = 1'b1;
    for (int n = 0; n < 400 && !out_ack; n++) step();
    chk("ar_ack", 32'(out_ack), 32'd1);
    chk("ar_cnt", 32'(fifo_count), 32'd2);
    #2 rst_b = 1'b0;
    #1;
    chk("ar_ack0", 32'(out_ack), 32'd0);
    chk("ar_cnt0", 32'(fifo_count), 32'd0);
    chk("ar_valid0", 32'(disp_valid), 32'd0);
    out_req = 1'b0;
    idle(2);
    rst_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("ar_nopop", 32'(disp_valid), 32'd0);
    end
    for (int i = 0; i < 3000; i++) begin
      step();
      flush = $urandom_range(0, 49) == 0;
      if (out_req && out_ack) out_req = 1'b0;
      else if (!out_req && !out_ack && $urandom_range(0, 2) == 0) begin
        out_req = 1'b1;
        out_data = 16'($urandom);
        out_fmt = 2'($urandom);
      end
    end
    flush = 1'b0;
    out_req = 1'b0;
    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
